// File: rtl/cacheline_arbiter.sv
// Arbitrates an I-cache and a D-cache onto one cacheline memory port.
// One transaction in flight; the request is latched at grant and the response is routed back to its owner.
module cacheline_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_W    = 256,
    parameter int unsigned OFFSET_W  = 5,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        RESP
    } state_e;

    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_W;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;
    // owner_q / last_q: 1 = D-cache, 0 = I-cache
    logic              owner_q;
    logic              last_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              i_resp_q;
    logic              d_resp_q;

    logic              i_act;
    logic              d_act;
    logic              grant_d;
    logic              wr_d;
    logic [ADDR_W-1:0] addr_d;
    logic [LINE_W-1:0] wdata_d;

    always_comb begin
        i_act = i_read | i_write;
        d_act = d_read | d_write;
        if (i_act && d_act) begin
            grant_d = (PRIO_MODE != 0) ? 1'b1 : ~last_q;
        end else begin
            grant_d = d_act;
        end
        // A read+write request from the winner is issued as a write.
        wr_d    = grant_d ? d_write : i_write;
        addr_d  = (grant_d ? d_addr : i_addr) & LINE_MASK;
        wdata_d = grant_d ? d_wdata : i_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_resp_q    <= 1'b0;
            d_resp_q    <= 1'b0;
        end else begin
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_act || d_act) begin
                        addr_q      <= addr_d;
                        wdata_q     <= wdata_d;
                        owner_q     <= grant_d;
                        last_q      <= grant_d;
                        mem_read_q  <= ~wr_d;
                        mem_write_q <= wr_d;
                        state_q     <= MEM;
                    end
                end
                MEM: begin
                    if (mem_resp) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (!mem_write_q) begin
                            if (owner_q) begin
                                d_rdata_q <= mem_rdata;
                            end else begin
                                i_rdata_q <= mem_rdata;
                            end
                        end
                        if (owner_q) begin
                            d_resp_q <= 1'b1;
                        end else begin
                            i_resp_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_resp    = i_resp_q;
    assign d_resp    = d_resp_q;

endmodule
